// File: rtl/fifo_fwft_pkg.sv
// Shared types for the fifo_fwft slice: the per-cycle operation decode
// that drives pointers, fill and the RAM ports.
package fifo_fwft_pkg;

  typedef struct packed {
    logic wr;    // write accepted into the RAM
    logic rd;    // head word consumed by the reader
    logic ovw;   // oldest word discarded to make room for a write
    logic load;  // RAM read issued into the output register
    logic adv;   // read pointer advances
  } fifo_op_t;

endpackage

// File: rtl/fifo_defs.vh
// Shared FIFO macros: depth derivation, default thresholds, parameter checks.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FIFO_DEPTH(aw) (1 << (aw))
`define FIFO_AE_DEFAULT 4
`define FIFO_AF_MARGIN 4

`define FIFO_CHECK_PARAMS(aw, depth, ae, af) \
  if ((aw) < 2 || (ae) > (depth) || (af) > (depth)) begin : g_param_err \
    $error("fifo: illegal ADDR_WIDTH / threshold parameters"); \
  end

`endif

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with a registered, read-enabled output; maps to EBR.
// A read and write to the same address in one cycle returns the old word.
module fifo_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_rdata <= '0;
    else if (i_re) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/fifo_fwft.sv
// Single-clock FIFO with FWFT or standard read, registered fill, almost
// thresholds, sticky overflow/underflow and optional overwrite-oldest.
`include "fifo_defs.vh"

module fifo_fwft
  import fifo_fwft_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int OVERWRITE_OLD = 0,
  parameter int FWFT          = 1,
  parameter int AF_LEVEL      = `FIFO_DEPTH(ADDR_WIDTH) - `FIFO_AF_MARGIN,
  parameter int AE_LEVEL      = `FIFO_AE_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_empty,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   o_fill,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = `FIFO_DEPTH(ADDR_WIDTH);
  localparam int PW    = ADDR_WIDTH + 1;

  `FIFO_CHECK_PARAMS(ADDR_WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)

  logic [PW-1:0]         wptr, rptr, fill;
  logic                  valid, ovf, unf, ram_ne;
  logic [DATA_WIDTH-1:0] ram_q;
  fifo_op_t              op;

  // Fill counts the output register too, so all flags decode from it alone.
  assign ram_ne         = (wptr != rptr);
  assign o_empty        = (fill == '0);
  assign o_full         = (fill == PW'(DEPTH));
  assign o_almost_empty = (fill <= PW'(AE_LEVEL));
  assign o_almost_full  = (fill >= PW'(AF_LEVEL));
  assign o_fill         = fill;
  assign o_valid        = valid;
  assign o_data         = ram_q;
  assign o_overflow     = ovf;
  assign o_underflow    = unf;

  always_comb begin
    op = '0;
    if (FWFT != 0) op.rd = i_rd && valid;
    else           op.rd = i_rd && !o_empty;
    op.wr  = i_wr && (!o_full || op.rd || (OVERWRITE_OLD != 0));
    op.ovw = i_wr && o_full && !op.rd && (OVERWRITE_OLD != 0);
    // FWFT prefetches whenever the head slot frees up; standard mode reads on demand.
    if (FWFT != 0) begin
      op.load = ram_ne && (!valid || op.rd || op.ovw);
      op.adv  = op.load;
    end else begin
      op.load = op.rd;
      op.adv  = op.rd || op.ovw;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      fill  <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (i_en) begin
      if (op.wr)  wptr <= wptr + PW'(1);
      if (op.adv) rptr <= rptr + PW'(1);
      if (op.wr && !op.rd && !op.ovw) fill <= fill + PW'(1);
      else if (op.rd && !op.wr)       fill <= fill - PW'(1);
      if (FWFT != 0) valid <= op.load || (valid && !op.rd);
      else           valid <= op.rd;
      ovf <= (ovf && !i_clr_err) || (i_wr && o_full && !op.rd);
      unf <= (unf && !i_clr_err) || (i_rd && !op.rd);
    end
  end

  fifo_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (i_en && !i_rst && op.wr),
    .i_waddr(wptr[ADDR_WIDTH-1:0]),
    .i_wdata(i_data),
    .i_re   (i_en && !i_rst && op.load),
    .i_raddr(rptr[ADDR_WIDTH-1:0]),
    .o_rdata(ram_q)
  );

endmodule

// File: doc/fifo_fwft.md
Name: fifo_fwft

Overview:
- Parametrised successor to the team's single-clock FIFO; targets iCE40 EBR through a registered-read RAM.
- Adds first-word-fall-through (FWFT) or standard read mode, a registered fill count and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow flags and keeps the optional overwrite-oldest mode.
- Sits between SDM decimator outputs and the host readout/UART path.

Parameters:
- ADDR_WIDTH, 8, log2 of capacity; DEPTH = 2^ADDR_WIDTH words; minimum 2.
- DATA_WIDTH, 8, word width.
- OVERWRITE_OLD, 0, 1 = a write when full discards the oldest word instead of being dropped.
- FWFT, 1, 1 = head word presented on o_data with o_valid; 0 = standard registered read.
- AF_LEVEL, DEPTH-4, o_almost_full asserted when fill >= AF_LEVEL.
- AE_LEVEL, 4, o_almost_empty asserted when fill <= AE_LEVEL.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_en  in  1  clock enable; low freezes all state
- i_wr  in  1  write request
- i_data  in  DATA_WIDTH  write data
- i_rd  in  1  read request (FWFT: acknowledge of head word)
- i_clr_err  in  1  clear sticky error flags
- o_data  out  DATA_WIDTH  read data
- o_valid  out  1  o_data holds a valid word
- o_empty  out  1  fill == 0
- o_full  out  1  fill == DEPTH
- o_almost_empty  out  1  fill <= AE_LEVEL
- o_almost_full  out  1  fill >= AF_LEVEL
- o_fill  out  ADDR_WIDTH+1  words held, including the FWFT output register
- o_overflow  out  1  sticky: a write hit a full FIFO
- o_underflow  out  1  sticky: a read hit no data

Behaviour:
- Reset: clock i_clk, reset i_rst, synchronous, active-high. i_rst overrides i_en.
- Reset values:
  - o_fill=0, o_empty=1, o_almost_empty=1.
  - o_full=0, o_almost_full=0.
  - o_valid=0, o_data=0, o_overflow=0, o_underflow=0.
  - Pointers are cleared. RAM contents are not reset.
- Reset mid-operation discards all contents; any i_wr/i_rd in the same cycle is ignored.
- i_en=0: no pointer, fill, flag or o_data change; i_wr and i_rd are ignored and set no errors.
- All outputs are registered or decoded from registered fill only. There is no combinational path from any i_* to any o_*.
- Capacity: exactly DEPTH words in total (RAM plus output register). o_fill never exceeds DEPTH.
- Write acceptance: i_wr && (!o_full || read accepted same cycle || OVERWRITE_OLD).
- FWFT=1:
  - o_valid=1 means o_data is the head word. Read accepted = i_rd && o_valid.
  - The output register reloads from RAM when it is empty or being read and the RAM is non-empty.
  - Latency: a write to an empty FIFO at edge N gives o_valid=1 after edge N+1. o_fill=1 after edge N.
  - Back-to-back reads at 1 word/cycle are supported with no bubble while RAM is non-empty.
- FWFT=0:
  - Read accepted = i_rd && !o_empty.
  - o_data updates after the accepting edge. o_valid is a single-cycle pulse in that cycle.
  - o_data holds its value otherwise.
- Fill: +1 on accepted write only; -1 on accepted read only; unchanged on both or neither.
- Overwrite (OVERWRITE_OLD=1, full, write with no read):
  - The write is stored, the oldest word is discarded and fill stays DEPTH.
  - FWFT=1: the output register takes the next RAM word.
  - FWFT=0: the read pointer advances.
- Full with simultaneous read and write: both accepted, fill unchanged, no overflow.
- Empty with simultaneous read and write: the write is accepted; the read is rejected and sets o_underflow.
- o_overflow is set on i_wr && o_full with no accepted read, in both modes. Under OVERWRITE_OLD=0 that write is dropped.
- o_underflow is set on i_rd with no read accepted.
- i_clr_err clears both flags. A new error event in the same cycle wins (flag stays 1).
- Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH. The RAM is indexed by the low ADDR_WIDTH bits.
- Elaboration error if ADDR_WIDTH<2, AE_LEVEL>DEPTH or AF_LEVEL>DEPTH.

Decomposition:
- Shared include fifo_defs.vh: DEPTH derivation macro, parameter-check macro, default threshold constants.
- One sub-module, fifo_ram: simple dual-port, one write port, registered read with read-enable, parameters ADDR_WIDTH/DATA_WIDTH. It infers EBR.
- fifo_fwft holds the pointers, fill counter, output/prefetch register and flags.

Test Plan:
- ADDR_WIDTH=2, FWFT=1: write 0x11 at edge 0 into an empty FIFO -> o_fill=1 after edge 0; o_valid=1, o_data=0x11 after edge 1; i_rd at edge 2 -> o_empty=1, o_valid=0.
- Fill with 0xA0..0xA3 -> o_full=1, o_fill=4. Write 0xA4 (OVERWRITE_OLD=0) -> dropped, o_overflow=1. Drain reads 0xA0..0xA3 in order.
- Same bench with OVERWRITE_OLD=1: write 0xA4 when full -> o_fill stays 4, o_overflow=1. Drain reads 0xA1,0xA2,0xA3,0xA4.
- Full FIFO, i_wr and i_rd together for 10 cycles with incrementing data -> o_fill stays 4, no flags, output sequence continuous.
- Read on empty with a simultaneous write of 0x55 -> o_underflow=1, 0x55 retained, o_fill=1. Then i_clr_err -> both flags 0.
- FWFT=0, AE_LEVEL=1, AF_LEVEL=3; i_en toggling and i_rst asserted mid-fill (i_en low):
  - o_data appears one cycle after the accepting read.
  - No state change while i_en=0.
  - Almost flags track fill 0..4.
  - Reset returns all outputs to reset values.
